amm_cfg_loader: RTL

// - Avalon-MM master sequencer that programs the control register block: disables matching,

---
 rtl/amm_cfg_loader_if.sv | 23 ++
 rtl/amm_cfg_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/amm_cfg_loader_if.sv
// Avalon-MM bus between the config loader (master) and the control register block (slave).
interface avalon_mm_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, write, writedata, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, write, writedata, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/amm_cfg_loader.sv
// Avalon-MM sequencer that programs the matcher control registers:
// disable (0x0 <- 0), key words to 0x1..0x(REG_DEPTH-1), then enable word to 0x0.
// Optional feature macro: AMM_CFG_READBACK_EN adds a verified readback of the key words
// before the enable write; a mismatch or missing readdatavalid leaves the matcher disabled.
module amm_cfg_loader #(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned REG_DEPTH  = 4,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic                                clk_i,
  input  logic                                srst_n_i,
  input  logic                                start_i,
  input  logic [REG_DEPTH-2:0][REG_WIDTH-1:0] pattern_i,
  input  logic                                enable_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                error_o,
  avalon_mm_if.master                         amm_master_if
);

  localparam int unsigned PAT_WIDTH = REG_DEPTH - 1;
  localparam int unsigned ADDR_W    = REG_DEPTH;
  localparam int unsigned K_W       = $clog2(PAT_WIDTH) + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(PAT_WIDTH - 1);
`ifdef AMM_CFG_READBACK_EN
  localparam int unsigned T_W       = $clog2(RD_TIMEOUT + 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(RD_TIMEOUT - 1);
`endif

  // Reject parameter sets the sequencer cannot work with.
  if (RD_TIMEOUT < 2) begin : g_bad_rd_timeout
    $error("amm_cfg_loader: RD_TIMEOUT must be >= 2");
  end
  if (REG_DEPTH < 2) begin : g_bad_reg_depth
    $error("amm_cfg_loader: REG_DEPTH must be >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DIS,
    ST_WR_PAT,
`ifdef AMM_CFG_READBACK_EN
    ST_RD_REQ,
    ST_RD_WAIT,
`endif
    ST_WR_CTRL,
    ST_DONE
  } state_t;

  state_t                                state_q, state_d;
  logic [K_W-1:0]                        k_q, k_d;
  logic [PAT_WIDTH-1:0][REG_WIDTH-1:0]   pat_q, pat_d;
  logic                                  en_q, en_d;
  logic                                  err_q, err_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;
  logic                                  write_q, write_d;
  logic                                  read_q, read_d;
  logic [ADDR_W-1:0]                     address_q, address_d;
  logic [REG_WIDTH-1:0]                  wdata_q, wdata_d;
  logic [REG_WIDTH-1:0]                  pat_at_kd;
`ifdef AMM_CFG_READBACK_EN
  logic [T_W-1:0]                        tmo_q, tmo_d;
  logic [REG_WIDTH-1:0]                  pat_at_kq;
`endif

  // Next state, sequencing counters and the registered bus/status values for the next cycle.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pat_d     = pat_q;
    en_d      = en_q;
    err_d     = err_q;
    pat_at_kd = '0;
`ifdef AMM_CFG_READBACK_EN
    tmo_d     = tmo_q;
    pat_at_kq = '0;
    for (int unsigned p = 0; p < PAT_WIDTH; p++) begin
      if (k_q == K_W'(p)) pat_at_kq = pat_q[p];
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pat_d   = pattern_i;
          en_d    = enable_i;
          err_d   = 1'b0;
          state_d = ST_WR_DIS;
        end
      end
      ST_WR_DIS: begin
        if (!amm_master_if.waitrequest) begin
          k_d     = '0;
          state_d = ST_WR_PAT;
        end
      end
      ST_WR_PAT: begin
        if (!amm_master_if.waitrequest) begin
          if (k_q == K_LAST) begin
`ifdef AMM_CFG_READBACK_EN
            k_d     = '0;
            state_d = ST_RD_REQ;
`else
            state_d = ST_WR_CTRL;
`endif
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
`ifdef AMM_CFG_READBACK_EN
      ST_RD_REQ: begin
        if (!amm_master_if.waitrequest) begin
          tmo_d   = '0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (amm_master_if.readdatavalid) begin
          if (amm_master_if.readdata != pat_at_kq) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (k_q == K_LAST) begin
            state_d = ST_WR_CTRL;
          end else begin
            k_d     = k_q + K_W'(1);
            state_d = ST_RD_REQ;
          end
        end else if (tmo_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + T_W'(1);
        end
      end
`endif
      ST_WR_CTRL: begin
        if (!amm_master_if.waitrequest) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int unsigned p = 0; p < PAT_WIDTH; p++) begin
      if (k_d == K_W'(p)) pat_at_kd = pat_d[p];
    end

    write_d   = 1'b0;
    read_d    = 1'b0;
    address_d = '0;
    wdata_d   = '0;
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    case (state_d)
      ST_WR_DIS: begin
        write_d = 1'b1;
      end
      ST_WR_PAT: begin
        write_d   = 1'b1;
        address_d = ADDR_W'(k_d) + ADDR_W'(1);
        wdata_d   = pat_at_kd;
      end
`ifdef AMM_CFG_READBACK_EN
      ST_RD_REQ: begin
        read_d    = 1'b1;
        address_d = ADDR_W'(k_d) + ADDR_W'(1);
      end
`endif
      ST_WR_CTRL: begin
        write_d = 1'b1;
        wdata_d = {{(REG_WIDTH-1){1'b0}}, en_d};
      end
      default: begin
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any run in progress.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      pat_q     <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
`ifdef AMM_CFG_READBACK_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pat_q     <= pat_d;
      en_q      <= en_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      write_q   <= write_d;
      read_q    <= read_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
`ifdef AMM_CFG_READBACK_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign error_o                 = err_q;
  assign amm_master_if.address   = address_q;
  assign amm_master_if.write     = write_q;
  assign amm_master_if.writedata = wdata_q;
  assign amm_master_if.read      = read_q;

endmodule
